// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and segment constants for the 7-segment display arbiter.
// Pure declarations; no logic, no latency.
package seg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] SEG_IDLE  = 8'h02;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_ALL   = 8'hFF;

    // Index width that stays legal (>=1 bit) even for a single-entry vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Request/display bundle between sequence-detector channels and the display arbiter.
// master = requester side (drives valid/pattern), slave = arbiter side.
interface seg_display_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_seg;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           seg_out;
    logic                 busy;
    logic [2:0]           owner;

    modport master (
        output req_valid, req_seg,
        input  req_ready, seg_out, busy, owner
    );

    modport slave (
        input  req_valid, req_seg,
        output req_ready, seg_out, busy, owner
    );
endinterface

// File: rtl/seg_display_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer wins.
// Zero latency; purely combinational, no backpressure of its own.
module rr_picker
    import seg_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_idx,
    output logic               o_any
);
    localparam int SW = IW + 1;

    logic [SW-1:0] w_sum;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Walk ptr, ptr+1, ... modulo NUM_REQ; the extra sum bit holds the carry.
            w_sum = {1'b0, i_ptr} + SW'(k);
            if (w_sum >= SW'(NUM_REQ)) begin
                w_sum = w_sum - SW'(NUM_REQ);
            end
            if (!o_any && i_req[w_sum[IW-1:0]]) begin
                o_any                    = 1'b1;
                o_idx                    = w_sum[IW-1:0];
                o_grant[w_sum[IW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin share of one 7-seg display: grant in IDLE (0-cycle req_ready), show HOLD_CYCLES, 1 blank GAP.
// Requests wait while SHOW/GAP is active. Optional blink during SHOW under SEG_ARB_BLINK_EN.
module seg_display_arbiter
    import seg_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int BLINK_HALF  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    seg_display_arbiter_if.slave bus
);
    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_CYCLES < 1 || BLINK_HALF < 1) begin : g_bad_param
        $error("seg_display_arbiter: parameter out of range");
    end

    state_t             r_state, w_state_nxt;
    logic [IW-1:0]      r_ptr,   w_ptr_nxt;
    logic [7:0]         r_pat,   w_pat_nxt;
    logic [CW-1:0]      r_cnt,   w_cnt_nxt;
    logic [7:0]         r_seg,   w_seg_nxt;
    logic               r_busy,  w_busy_nxt;
    logic [2:0]         r_owner, w_owner_nxt;

    logic [NUM_REQ-1:0] w_grant;
    logic [IW-1:0]      w_idx;
    logic               w_any;
    logic [7:0]         w_req_pat;

`ifdef SEG_ARB_BLINK_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    logic [BW-1:0]      r_blk_cnt, w_blk_cnt_nxt;
    logic               r_blk_off, w_blk_off_nxt;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_req_pat     = bus.req_seg[{w_idx, 3'b000} +: 8];
    assign bus.req_ready = (r_state == IDLE) ? w_grant : '0;
    assign bus.seg_out   = r_seg;
    assign bus.busy      = r_busy;
    assign bus.owner     = r_owner;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_pat_nxt   = r_pat;
        w_cnt_nxt   = r_cnt;
        w_seg_nxt   = r_seg;
        w_busy_nxt  = r_busy;
        w_owner_nxt = r_owner;
`ifdef SEG_ARB_BLINK_EN
        w_blk_cnt_nxt = r_blk_cnt;
        w_blk_off_nxt = r_blk_off;
`endif
        case (r_state)
            IDLE: begin
                w_seg_nxt  = SEG_IDLE;
                w_busy_nxt = 1'b0;
                if (w_any) begin
                    w_state_nxt = SHOW;
                    w_ptr_nxt   = (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);
                    w_pat_nxt   = w_req_pat;
                    w_cnt_nxt   = CW'(HOLD_CYCLES - 1);
                    w_seg_nxt   = w_req_pat;
                    w_busy_nxt  = 1'b1;
                    w_owner_nxt = 3'(w_idx);
`ifdef SEG_ARB_BLINK_EN
                    w_blk_cnt_nxt = '0;
                    w_blk_off_nxt = 1'b0;
`endif
                end
            end
            SHOW: begin
                if (r_cnt == '0) begin
                    w_state_nxt = GAP;
                    w_seg_nxt   = SEG_BLANK;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
`ifdef SEG_ARB_BLINK_EN
                    // seg_out is registered, so it follows the phase of the upcoming cycle.
                    if (r_blk_cnt == BW'(BLINK_HALF - 1)) begin
                        w_blk_cnt_nxt = '0;
                        w_blk_off_nxt = ~r_blk_off;
                    end else begin
                        w_blk_cnt_nxt = r_blk_cnt + BW'(1);
                    end
                    w_seg_nxt = w_blk_off_nxt ? SEG_BLANK : r_pat;
`else
                    w_seg_nxt = r_pat;
`endif
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
                w_seg_nxt   = SEG_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_seg_nxt   = SEG_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_pat   <= SEG_BLANK;
            r_cnt   <= '0;
            r_seg   <= SEG_IDLE;
            r_busy  <= 1'b0;
            r_owner <= '0;
`ifdef SEG_ARB_BLINK_EN
            r_blk_cnt <= '0;
            r_blk_off <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_pat   <= w_pat_nxt;
            r_cnt   <= w_cnt_nxt;
            r_seg   <= w_seg_nxt;
            r_busy  <= w_busy_nxt;
            r_owner <= w_owner_nxt;
`ifdef SEG_ARB_BLINK_EN
            r_blk_cnt <= w_blk_cnt_nxt;
            r_blk_off <= w_blk_off_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter: reset, single grant, round-robin, late arrival, reset mid-SHOW.
// Expected SHOW pattern follows the blink phase when SEG_ARB_BLINK_EN is defined.
module tb_seg_display_arbiter;
    import seg_arb_pkg::*;

    localparam int NR = 4;
    localparam int HC = 16;
    localparam int BH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    seg_display_arbiter_if #(.NUM_REQ(NR)) bus ();

    seg_display_arbiter #(
        .NUM_REQ     (NR),
        .HOLD_CYCLES (HC),
        .BLINK_HALF  (BH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [7:0] show_exp(input logic [7:0] pat, input int k);
`ifdef SEG_ARB_BLINK_EN
        return (((k / BH) % 2) == 1) ? SEG_BLANK : pat;
`else
        return (k >= 0) ? pat : SEG_BLANK;
`endif
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_seg   = '0;
        repeat (3) tick();
        total++; if (bus.seg_out !== 8'h02) begin bad++; $display("FAIL rst_seg: got %h want 02", bus.seg_out); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        total++; if (bus.owner !== 3'd0) begin bad++; $display("FAIL rst_owner: got %0d want 0", bus.owner); end
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready: got %b want 0000", bus.req_ready); end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            total++; if (bus.seg_out !== 8'h02 || bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) begin
                bad++; $display("FAIL idle_cyc%0d: seg=%h busy=%b ready=%b want 02/0/0000", i, bus.seg_out, bus.busy, bus.req_ready);
            end
            tick();
        end
    endtask

    task automatic test_single();
        bus.req_seg   = {8'h44, SEG_ALL, 8'h22, 8'h11};
        bus.req_valid = 4'b0100;
        #1;
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        for (int k = 0; k < HC; k++) begin
            total++; if (bus.seg_out !== show_exp(8'hFF, k) || bus.busy !== 1'b1 || bus.owner !== 3'd2) begin
                bad++; $display("FAIL single_show%0d: seg=%h busy=%b owner=%0d want %h/1/2", k, bus.seg_out, bus.busy, bus.owner, show_exp(8'hFF, k));
            end
            tick();
        end
        total++; if (bus.seg_out !== 8'h00 || bus.busy !== 1'b1) begin bad++; $display("FAIL single_gap: seg=%h busy=%b want 00/1", bus.seg_out, bus.busy); end
        tick();
        total++; if (bus.seg_out !== 8'h02 || bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle: seg=%h busy=%b want 02/0", bus.seg_out, bus.busy); end
        total++; if (bus.owner !== 3'd2) begin bad++; $display("FAIL single_owner_hold: got %0d want 2", bus.owner); end
    endtask

    task automatic test_round_robin();
        logic [7:0] pats [4];
        int t_prev;
        int idx;
        pats = '{8'h11, 8'h22, 8'h33, 8'h44};
        t_prev = 0;
        do_reset();
        bus.req_seg   = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            idx = g % NR;
            #1;
            total++; if (bus.req_ready !== 4'(1 << idx)) begin bad++; $display("FAIL rr_ready%0d: got %b want %b", g, bus.req_ready, 4'(1 << idx)); end
            if (g > 0) begin
                total++; if (cyc - t_prev !== 18) begin bad++; $display("FAIL rr_period%0d: got %0d want 18", g, cyc - t_prev); end
            end
            t_prev = cyc;
            tick();
            total++; if (bus.owner !== 3'(idx) || bus.seg_out !== pats[idx]) begin
                bad++; $display("FAIL rr_grant%0d: owner=%0d seg=%h want %0d/%h", g, bus.owner, bus.seg_out, idx, pats[idx]);
            end
            repeat (HC) tick();
            total++; if (bus.req_ready !== 4'b0000 || bus.seg_out !== 8'h00) begin
                bad++; $display("FAIL rr_gap%0d: ready=%b seg=%h want 0000/00", g, bus.req_ready, bus.seg_out);
            end
            tick();
        end
        bus.req_valid = '0;
    endtask

    task automatic test_late_arrival();
        do_reset();
        bus.req_seg   = {8'h44, 8'h33, 8'hA5, 8'h5A};
        bus.req_valid = 4'b0001;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL late_first_ready: got %b want 0001", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        repeat (3) tick();
        bus.req_valid = 4'b0010;
        for (int i = 0; i < HC - 2; i++) begin
            #1;
            total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL late_wait%0d: ready=%b want 0000", i, bus.req_ready); end
            tick();
        end
        #1;
        total++; if (bus.req_ready !== 4'b0010 || bus.seg_out !== 8'h02) begin
            bad++; $display("FAIL late_idle: ready=%b seg=%h want 0010/02", bus.req_ready, bus.seg_out);
        end
        tick();
        total++; if (bus.owner !== 3'd1 || bus.seg_out !== 8'hA5) begin
            bad++; $display("FAIL late_grant: owner=%0d seg=%h want 1/a5", bus.owner, bus.seg_out);
        end
        bus.req_valid = '0;
        repeat (HC + 1) tick();
    endtask

    task automatic test_reset_mid_show();
        do_reset();
        bus.req_seg   = {8'h44, 8'hC3, 8'h22, 8'h11};
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        repeat (4) tick();
        total++; if (bus.seg_out !== show_exp(8'hC3, 4) || bus.owner !== 3'd2) begin
            bad++; $display("FAIL mid_before: seg=%h owner=%0d want %h/2", bus.seg_out, bus.owner, show_exp(8'hC3, 4));
        end
        reset = 1'b1;
        #1;
        total++; if (bus.seg_out !== 8'h02 || bus.busy !== 1'b0 || bus.owner !== 3'd0) begin
            bad++; $display("FAIL mid_reset: seg=%h busy=%b owner=%0d want 02/0/0", bus.seg_out, bus.busy, bus.owner);
        end
        tick();
        reset = 1'b0;
        bus.req_seg   = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req_valid = 4'b1111;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL mid_ptr: ready=%b want 0001", bus.req_ready); end
        tick();
        total++; if (bus.owner !== 3'd0 || bus.seg_out !== 8'h11) begin
            bad++; $display("FAIL mid_regrant: owner=%0d seg=%h want 0/11", bus.owner, bus.seg_out);
        end
        bus.req_valid = '0;
        repeat (HC + 1) tick();
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_seg   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_late_arrival();
        test_reset_mid_show();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the single 7-segment output (uo_out) between several sequence-detector channels. Each channel posts an 8-bit segment pattern through a valid/ready handshake. The arbiter grants channels round-robin and holds each granted pattern on the display for a fixed number of cycles, then inserts one blank cycle. With no pending request it shows the idle dash.

## Interface
Parameters:
- NUM_REQ, default 4: number of requesting channels, 2..8.
- HOLD_CYCLES, default 16: cycles a granted pattern stays displayed, ≥1.
- BLINK_HALF, default 4: blink half-period in cycles, used only with SEG_ARB_BLINK_EN, ≥1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  channel i has a pattern pending.
- req_seg  in  8*NUM_REQ  pattern of channel i in bits [8i+7:8i]; must stay stable while req_valid[i]=1 and not yet accepted.
- req_ready  out  NUM_REQ  one-hot acceptance strobe; combinational from state, pointer and req_valid.
- seg_out  out  8  registered segment drive to uo_out; bit 7 = decimal point.
- busy  out  1  registered; 1 in SHOW or GAP.
- owner  out  3  registered index of the channel currently displayed; holds its last value outside SHOW.

## Operation
- Reset values: state=IDLE, rr pointer=0, seg_out=8'h02 (dash), busy=0, owner=0, hold counter=0.
- States:
  - IDLE: seg_out=8'h02. If any req_valid is set, select the winner w. Search order is ptr, ptr+1, … mod NUM_REQ. Drive req_ready[w]=1 in the same cycle. At the edge, latch req_seg[w], set owner=w and ptr=(w+1) mod NUM_REQ, load the counter with HOLD_CYCLES-1, and go to SHOW.
  - SHOW: seg_out=latched pattern. The counter decrements each cycle. When it reaches 0, go to GAP.
  - GAP: seg_out=8'h00 for exactly 1 cycle, then go to IDLE.
- req_ready is 0 in SHOW and GAP, and 0 for every non-winner. At most one bit is set per cycle.
- Acceptance is req_valid[i] & req_ready[i] on the same cycle. A requester may deassert req_valid before acceptance; the request is simply lost.
- Requests arriving during SHOW or GAP wait. They are evaluated in the first IDLE cycle.
- Back-to-back service: per grant, one accept cycle (IDLE) + HOLD_CYCLES (SHOW) + 1 (GAP). Period is HOLD_CYCLES+2 cycles with continuous demand.
- Counter width is $clog2(HOLD_CYCLES+1); it never wraps below 0.
- The pointer wraps from NUM_REQ-1 to 0.
- reset asserted mid-SHOW immediately forces the reset values, including seg_out=8'h02. The latched pattern is discarded.

## Timing
- Grant decision latency 0: req_ready rises in the same cycle req_valid is seen in IDLE.
- seg_out shows the pattern from the edge after acceptance, for HOLD_CYCLES cycles.
- busy rises with seg_out and falls on the edge that re-enters IDLE.
- No combinational path from req_seg to seg_out.

## Configuration
- SEG_ARB_BLINK_EN defined:
  - During SHOW, seg_out alternates between the latched pattern and 8'h00 every BLINK_HALF cycles.
  - The phase starts with the pattern visible on the first SHOW cycle.
  - The blink counter resets on each grant.
- SEG_ARB_BLINK_EN undefined: the pattern is steady for all of SHOW, and no blink counter is synthesized.
- IDLE and GAP outputs are identical in both builds.

## Structure
- Package seg_arb_pkg holds:
  - state typedef {IDLE, SHOW, GAP};
  - constants SEG_IDLE=8'h02, SEG_BLANK=8'h00, SEG_ALL=8'hFF.
- Sub-module rr_picker(NUM_REQ) is purely combinational. Inputs are req vector and pointer; outputs are one-hot grant, encoded index and any_valid.
- Top holds the FSM, pattern register, hold and blink counters, and output registers.

## Test plan
- Reset then idle: hold reset 3 cycles, release, no requests → seg_out=8'h02, busy=0, req_ready=0 for 10 cycles.
- Single request (HOLD_CYCLES=16): req_valid=4'b0100, req_seg[2]=8'hFF in IDLE → req_ready=4'b0100 same cycle. Then seg_out=8'hFF for 16 cycles, 8'h00 for 1 cycle, 8'h02 after; owner=2.
- Round-robin fairness: all four valid continuously with distinct patterns 8'h11/22/33/44 → grant order 0,1,2,3,0 with period 18 cycles.
- Late arrival: channel 1 asserts valid during SHOW of channel 0 → req_ready[1] stays 0 until the first IDLE cycle after GAP.
- Reset mid-SHOW: assert reset on cycle 5 of SHOW → seg_out=8'h02 and busy=0 immediately; after release, the next grant starts from channel 0.
- SEG_ARB_BLINK_EN build, BLINK_HALF=4: single grant of 8'hFF → seg_out FF×4, 00×4, FF×4, 00×4, then GAP 00, then 02.
